// File: rtl/rfBlackWidowPkg.sv
// Shared BlackWidow definitions used by the I-cache invalidation sequencer.
package rfBlackWidowPkg;

    // Valid-array invalidate opcodes as seen on the CSR cache-control path.
    localparam logic [1:0] INV_LINE    = 2'b01;
    localparam logic [1:0] INV_ALL     = 2'b10;

    // Byte offset width of an I-cache line (128-byte lines).
    localparam int         IC_LINE_OFS = 7;

    // Consecutive snoop issues tolerated while a CSR line request waits.
    localparam logic [2:0] FAIR_LIMIT  = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HOLD} inv_state_t;
    typedef enum logic {SRC_SNP, SRC_CSR} inv_src_t;

endpackage

// File: rtl/bw_inv_fifo.sv
// Small synchronous FIFO for snoop line addresses. Flush empties it, but an
// entry pushed in the flush cycle survives as the sole entry.
module bw_inv_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head,
    output logic [W-1:0] tail
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rptr, wptr, tptr;
    logic [AW:0]   cnt;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign tptr  = wptr - AW'(1);
    assign head  = mem[rptr];
    assign tail  = mem[tptr];

    // Pointer and occupancy bookkeeping; flush restarts at slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            rptr <= '0;
            wptr <= push ? AW'(1) : '0;
            cnt  <= push ? (AW+1)'(1) : '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage write; a push during flush lands where the reset pointer points.
    always_ff @(posedge clk) begin
        if (push) mem[flush ? '0 : wptr] <= din;
    end

endmodule

// File: rtl/bw_icache_inv_ctrl.sv
// I-cache valid-array invalidation sequencer: arbitrates CSR and snoop
// invalidates, defers around refill writes and flags stale refills.
module bw_icache_inv_ctrl
    import rfBlackWidowPkg::*;
#(
    parameter int AWID      = 32,
    parameter int LINES     = 128,
    parameter int SNP_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_req,
    input  logic [1:0]      csr_op,
    input  logic [AWID-1:0] csr_adr,
    output logic            csr_ack,
    input  logic            snp_valid,
    input  logic [AWID-1:0] snp_adr,
    output logic            snp_ready,
    input  logic            fill_wr,
    input  logic            refill_busy,
    input  logic [AWID-1:0] refill_adr,
    output logic            refill_stale,
    output logic            inv_ce,
    output logic            inv_line,
    output logic            inv_all,
    output logic [AWID-1:0] inv_adr,
    output logic            busy
);
    localparam int LW = AWID - IC_LINE_OFS;

    if (AWID < IC_LINE_OFS + $clog2(LINES)) begin : g_bad_awid
        $error("bw_icache_inv_ctrl: AWID too small for LINES");
    end

    inv_state_t      state_q, state_d;
    inv_src_t        src_q, src_d;
    logic [1:0]      op_q, op_d;
    logic [LW-1:0]   line_q, line_d;
    logic [2:0]      streak_q, streak_d;
    logic [LW-1:0]   snp_line, fifo_head, fifo_tail;
    logic            fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty, merge;
    logic            csr_all, csr_ln, fair, go, enter;
    logic            ce_d, line_o_d, all_d, ack_d, stale_d;
    logic [AWID-1:0] adr_d;
    logic            unused_ofs;

    // Offset bits never matter: every compare and issue is line-granular.
    assign unused_ofs = ^{csr_adr[IC_LINE_OFS-1:0], snp_adr[IC_LINE_OFS-1:0],
                          refill_adr[IC_LINE_OFS-1:0]};

    assign snp_line   = snp_adr[AWID-1:IC_LINE_OFS];
    assign fifo_pop   = (state_q == ST_ISSUE) && (src_q == SRC_SNP);
    assign fifo_flush = (state_q == ST_ISSUE) && (src_q == SRC_CSR) && (op_q == INV_ALL);
    // Only merge into an entry that is neither leaving nor being flushed.
    assign merge      = !fifo_empty && !fifo_flush && !fifo_pop && (fifo_tail == snp_line);
    assign snp_ready  = !fifo_full;
    assign fifo_push  = snp_valid && !fifo_full && !merge;

    assign csr_all = csr_req && (csr_op == INV_ALL);
    assign csr_ln  = csr_req && (csr_op == INV_LINE);
    assign fair    = csr_ln && (streak_q == FAIR_LIMIT);
    assign busy    = !fifo_empty || (csr_req && !csr_ack) || (state_q != ST_IDLE);

    bw_inv_fifo #(.DEPTH(SNP_DEPTH), .W(LW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (snp_line),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head),
        .tail  (fifo_tail)
    );

    // Source selection, fill deferral and next-cycle valid-array drive.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        op_d     = op_q;
        line_d   = line_q;
        streak_d = streak_q;
        go       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (csr_all) begin
                    src_d  = SRC_CSR;
                    op_d   = INV_ALL;
                    line_d = '0;
                    go     = 1'b1;
                end else if (!fifo_empty && !fair) begin
                    src_d    = SRC_SNP;
                    op_d     = INV_LINE;
                    line_d   = fifo_head;
                    go       = 1'b1;
                    streak_d = csr_ln ? streak_q + 3'd1 : '0;
                end else if (csr_req) begin
                    src_d    = SRC_CSR;
                    op_d     = csr_op;
                    line_d   = csr_adr[AWID-1:IC_LINE_OFS];
                    go       = 1'b1;
                    streak_d = '0;
                end
                if (go) state_d = fill_wr ? ST_HOLD : ST_ISSUE;
            end
            ST_HOLD: state_d = fill_wr ? ST_HOLD : ST_ISSUE;
            default: state_d = ST_IDLE;
        endcase

        enter    = (state_d == ST_ISSUE);
        line_o_d = enter && (op_d == INV_LINE);
        all_d    = enter && (op_d == INV_ALL);
        ce_d     = line_o_d || all_d;
        ack_d    = enter && (src_d == SRC_CSR);
        adr_d    = line_o_d ? {line_d, {IC_LINE_OFS{1'b0}}} : '0;
        stale_d  = refill_busy && (all_d ||
                   (line_o_d && (line_d == refill_adr[AWID-1:IC_LINE_OFS])));
    end

    // State and registered valid-array / handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            src_q        <= SRC_SNP;
            op_q         <= '0;
            line_q       <= '0;
            streak_q     <= '0;
            inv_ce       <= 1'b0;
            inv_line     <= 1'b0;
            inv_all      <= 1'b0;
            inv_adr      <= '0;
            csr_ack      <= 1'b0;
            refill_stale <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            op_q         <= op_d;
            line_q       <= line_d;
            streak_q     <= streak_d;
            inv_ce       <= ce_d;
            inv_line     <= line_o_d;
            inv_all      <= all_d;
            inv_adr      <= adr_d;
            csr_ack      <= ack_d;
            refill_stale <= stale_d;
        end
    end

endmodule

// File: tb/tb_bw_icache_inv_ctrl.sv
// Directed bench for bw_icache_inv_ctrl.
module tb_bw_icache_inv_ctrl;
    logic        clk, rst;
    logic        csr_req, csr_ack;
    logic [1:0]  csr_op;
    logic [31:0] csr_adr;
    logic        snp_valid, snp_ready;
    logic [31:0] snp_adr;
    logic        fill_wr, refill_busy, refill_stale;
    logic [31:0] refill_adr;
    logic        inv_ce, inv_line, inv_all, busy;
    logic [31:0] inv_adr;

    int checks = 0;
    int errors = 0;

    bw_icache_inv_ctrl #(.AWID(32), .LINES(128), .SNP_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .csr_req(csr_req), .csr_op(csr_op), .csr_adr(csr_adr), .csr_ack(csr_ack),
        .snp_valid(snp_valid), .snp_adr(snp_adr), .snp_ready(snp_ready),
        .fill_wr(fill_wr), .refill_busy(refill_busy), .refill_adr(refill_adr),
        .refill_stale(refill_stale),
        .inv_ce(inv_ce), .inv_line(inv_line), .inv_all(inv_all), .inv_adr(inv_adr),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until an inv_ce cycle (bounded) and check its address.
    task automatic wait_ce(input string tag, input logic [31:0] adr);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!inv_ce && n < 12);
        chk({tag, "_seen"}, {31'b0, inv_ce}, 32'd1);
        chk({tag, "_adr"}, inv_adr, adr);
    endtask

    initial begin
        logic [31:0] nadr;
        logic        acc, got;
        int          n_snp;

        rst = 1; csr_req = 0; csr_op = 2'b00; csr_adr = 0;
        snp_valid = 0; snp_adr = 0; fill_wr = 0; refill_busy = 0; refill_adr = 0;
        repeat (3) tick();
        rst = 0;
        tick();
        chk("rst_ce", {31'b0, inv_ce}, 0);
        chk("rst_ack", {31'b0, csr_ack}, 0);
        chk("rst_stale", {31'b0, refill_stale}, 0);
        chk("rst_adr", inv_adr, 0);
        chk("rst_ready", {31'b0, snp_ready}, 1);
        chk("rst_busy", {31'b0, busy}, 0);

        // Lone snoop: issue exactly two cycles after acceptance, one cycle wide.
        snp_valid = 1; snp_adr = 32'h0000_1280;
        tick();
        snp_valid = 0;
        chk("snp1_n1_ce", {31'b0, inv_ce}, 0);
        chk("snp1_n1_busy", {31'b0, busy}, 1);
        tick();
        chk("snp1_ce", {29'b0, inv_ce, inv_line, inv_all}, 32'b110);
        chk("snp1_adr", inv_adr, 32'h0000_1280);
        tick();
        chk("snp1_one_cycle", {31'b0, inv_ce}, 0);
        chk("snp1_idle_busy", {31'b0, busy}, 0);

        // CSR invalidate-all with 3 queued snoops (fill holds it off), refill busy.
        refill_busy = 1; refill_adr = 32'h4000_0380;
        csr_req = 1; csr_op = 2'b10; csr_adr = 0; fill_wr = 1;
        snp_valid = 1; snp_adr = 32'h0000_0100;
        tick(); snp_adr = 32'h0000_0200;
        tick(); snp_adr = 32'h0000_0300;
        tick(); snp_valid = 0; fill_wr = 0;
        chk("all_held_ce", {31'b0, inv_ce}, 0);
        chk("all_held_busy", {31'b0, busy}, 1);
        tick();
        chk("all_issue", {29'b0, inv_ce, inv_line, inv_all}, 32'b101);
        chk("all_ack", {31'b0, csr_ack}, 1);
        chk("all_stale", {31'b0, refill_stale}, 1);
        chk("all_adr", inv_adr, 0);
        csr_req = 0; snp_valid = 1; snp_adr = 32'h0000_0500;
        tick();
        snp_valid = 0;
        chk("all_after_ce", {31'b0, inv_ce}, 0);
        chk("all_after_ack", {31'b0, csr_ack}, 0);
        chk("all_retained_busy", {31'b0, busy}, 1);
        tick();
        chk("all_retained_adr", inv_adr, 32'h0000_0500);
        chk("all_retained_ce", {31'b0, inv_ce}, 1);
        chk("all_retained_nostale", {31'b0, refill_stale}, 0);
        tick();
        chk("all_flushed_ce", {31'b0, inv_ce}, 0);
        chk("all_flushed_busy", {31'b0, busy}, 0);
        refill_busy = 0;

        // Ignored CSR op: ack one cycle later, nothing issued.
        csr_req = 1; csr_op = 2'b11; csr_adr = 32'h0000_5555;
        tick();
        chk("nop_ack", {31'b0, csr_ack}, 1);
        chk("nop_ce", {31'b0, inv_ce}, 0);
        csr_req = 0;
        tick();
        chk("nop_ack_pulse", {31'b0, csr_ack}, 0);
        chk("nop_busy", {31'b0, busy}, 0);

        // CSR line request: ack and issue in the next cycle.
        csr_req = 1; csr_op = 2'b01; csr_adr = 32'h0000_ABFF;
        tick();
        chk("csrl_issue", {29'b0, inv_ce, inv_line, inv_all}, 32'b110);
        chk("csrl_ack", {31'b0, csr_ack}, 1);
        chk("csrl_adr", inv_adr, 32'h0000_AB80);
        csr_req = 0;
        tick();
        chk("csrl_ack_pulse", {31'b0, csr_ack}, 0);

        // Line request deferred by three fill_wr cycles.
        csr_req = 1; csr_op = 2'b01; csr_adr = 32'h0000_2345; fill_wr = 1;
        tick(); chk("fill_c1", {31'b0, inv_ce}, 0);
        tick(); chk("fill_c2", {31'b0, inv_ce}, 0);
        tick(); chk("fill_c3", {30'b0, inv_ce, csr_ack}, 0);
        fill_wr = 0;
        tick();
        chk("fill_issue", {30'b0, inv_ce, csr_ack}, 32'b11);
        chk("fill_adr", inv_adr, 32'h0000_2300);
        csr_req = 0;
        tick();
        chk("fill_done", {31'b0, inv_ce}, 0);

        // FIFO full after 4 snoops; fifth waits for the first pop.
        fill_wr = 1; snp_valid = 1; snp_adr = 32'h0000_1000;
        tick(); snp_adr = 32'h0000_1080;
        tick(); snp_adr = 32'h0000_1100;
        tick(); snp_adr = 32'h0000_1180;
        tick(); snp_adr = 32'h0000_1200;
        chk("full_ready", {31'b0, snp_ready}, 0);
        fill_wr = 0;
        tick();
        chk("full_first_adr", inv_adr, 32'h0000_1000);
        chk("full_first_ce", {31'b0, inv_ce}, 1);
        chk("full_ready_issue", {31'b0, snp_ready}, 0);
        tick();
        chk("full_ready_pop", {31'b0, snp_ready}, 1);
        tick();
        snp_valid = 0;
        chk("full_q2_adr", inv_adr, 32'h0000_1080);
        wait_ce("full_q3", 32'h0000_1100);
        wait_ce("full_q4", 32'h0000_1180);
        wait_ce("full_q5", 32'h0000_1200);
        tick(); tick();
        chk("full_drained", {31'b0, busy}, 0);

        // Same-line snoops merge into one issue.
        snp_valid = 1; snp_adr = 32'h0000_1280;
        tick(); snp_adr = 32'h0000_12C0;
        tick(); snp_valid = 0;
        chk("merge_adr", inv_adr, 32'h0000_1280);
        chk("merge_ce", {31'b0, inv_ce}, 1);
        tick();
        chk("merge_single_busy", {31'b0, busy}, 0);
        tick();
        chk("merge_single_ce", {31'b0, inv_ce}, 0);

        // Stale refill detection.
        refill_busy = 1; refill_adr = 32'h4000_0380;
        snp_valid = 1; snp_adr = 32'h4000_03A4;
        tick(); snp_valid = 0;
        tick();
        chk("stale_hit", {31'b0, refill_stale}, 1);
        chk("stale_hit_adr", inv_adr, 32'h4000_0380);
        tick();
        chk("stale_pulse", {31'b0, refill_stale}, 0);
        snp_valid = 1; snp_adr = 32'h4000_0400;
        tick(); snp_valid = 0;
        tick();
        chk("stale_miss_ce", {31'b0, inv_ce}, 1);
        chk("stale_miss", {31'b0, refill_stale}, 0);
        tick();
        refill_busy = 0;

        // Snoop stream vs CSR line request: CSR wins after 4 snoop issues.
        nadr = 32'h0000_8000; snp_adr = nadr; snp_valid = 1;
        for (int i = 0; i < 2; i++) begin
            acc = snp_ready;
            tick();
            if (acc) begin nadr = nadr + 32'h80; snp_adr = nadr; end
        end
        csr_req = 1; csr_op = 2'b01; csr_adr = 32'h0000_9900;
        n_snp = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            acc = snp_ready;
            tick();
            if (acc) begin nadr = nadr + 32'h80; snp_adr = nadr; end
            if (csr_ack) got = 1;
            else if (inv_ce) n_snp++;
        end
        chk("fair_ack_seen", {31'b0, got}, 1);
        chk("fair_snoops", n_snp, 4);
        chk("fair_adr", inv_adr, 32'h0000_9900);
        csr_req = 0; snp_valid = 0; fill_wr = 1;

        // Reset while held in HOLD with queued snoops.
        tick(); tick(); tick();
        chk("hold_busy", {31'b0, busy}, 1);
        rst = 1;
        tick();
        chk("rst2_outs", {26'b0, inv_ce, inv_line, inv_all, csr_ack, refill_stale, 1'b0}, 0);
        chk("rst2_adr", inv_adr, 0);
        chk("rst2_busy", {31'b0, busy}, 0);
        chk("rst2_ready", {31'b0, snp_ready}, 1);
        rst = 0; fill_wr = 0;
        tick(); tick();
        chk("rst2_no_issue", {31'b0, inv_ce}, 0);
        chk("rst2_idle", {31'b0, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
